// File: rtl/serial_uart_endpoint_if.sv
// Byte-serial CPU port bundle between the datapath and the UART endpoint.
//   cpu_data_in      : byte written by the CPU
//   cpu_wren_in      : CPU write strobe (push into TX FIFO when ready)
//   cpu_rden_in      : CPU read strobe (pop RX FIFO head when valid)
//   serial_data_out  : RX FIFO head byte, 8'h00 when empty
//   serial_valid_out : RX FIFO non-empty
//   serial_ready_out : TX FIFO not full
// master = CPU/datapath side, slave = endpoint side.
interface serial_uart_endpoint_if;
    logic [7:0] cpu_data_in;
    logic       cpu_wren_in;
    logic       cpu_rden_in;
    logic [7:0] serial_data_out;
    logic       serial_valid_out;
    logic       serial_ready_out;

    modport master (
        output cpu_data_in, cpu_wren_in, cpu_rden_in,
        input  serial_data_out, serial_valid_out, serial_ready_out
    );

    modport slave (
        input  cpu_data_in, cpu_wren_in, cpu_rden_in,
        output serial_data_out, serial_valid_out, serial_ready_out
    );
endinterface

// File: rtl/serial_uart_endpoint.sv
// UART endpoint for the processor's byte-serial port. CPU writes go through a
// TX FIFO and leave as 8N1 frames on uart_tx_out; 8N1 frames arriving on
// uart_rx_in are collected into an RX FIFO that the CPU pops.
// Ports:
//   clock, reset       : system clock, synchronous active-high reset
//   cpu                : CPU handshake bundle (slave modport)
//   uart_rx_in         : asynchronous receive line, idle high
//   uart_tx_out        : transmit line, idle high
//   rx_overflow_out    : sticky, a received byte was dropped (RX FIFO full)
//   rx_frame_err_out   : one-cycle pulse, stop bit sampled low, byte discarded
//
// Both FSMs share one state encoding:
//   state   | meaning
//   S_IDLE  | line idle; TX: pop FIFO head when present, RX: wait for low line
//   S_START | start bit; TX: drive 0, RX: half-bit wait then confirm low
//   S_DATA  | 8 data bits LSB first, one bit per CLKS_PER_BIT cycles
//   S_STOP  | stop bit; TX: drive 1, RX: sample, push or flag a frame error
module serial_uart_endpoint #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    serial_uart_endpoint_if.slave  cpu,
    input  logic                   uart_rx_in,
    output logic                   uart_tx_out,
    output logic                   rx_overflow_out,
    output logic                   rx_frame_err_out
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FIFO_AW:0]   FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    // ---------------- TX side ----------------
    logic [7:0]         tx_mem_q [DEPTH];
    logic [FIFO_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [FIFO_AW:0]   tx_cnt_q, tx_cnt_d;
    uart_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0]   tx_baud_q, tx_baud_d;
    logic [2:0]         tx_idx_q, tx_idx_d;
    logic [7:0]         tx_shift_q, tx_shift_d;
    logic               tx_push, tx_pop;

    // Acceptance looks only at the registered count, so a same-cycle pop
    // never lets a write into a full FIFO.
    assign tx_push              = cpu.cpu_wren_in && (tx_cnt_q != FULL_CNT);
    assign cpu.serial_ready_out = (tx_cnt_q != FULL_CNT);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                if (tx_cnt_q != '0) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_mem_q[tx_rd_ptr_q];
                    tx_baud_d  = '0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_baud_q == BIT_LAST) begin
                    tx_baud_d  = '0;
                    tx_idx_d   = '0;
                    tx_state_d = S_DATA;
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_baud_q == BIT_LAST) begin
                    tx_baud_d  = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_idx_d   = tx_idx_q + 3'd1;
                    if (tx_idx_q == 3'd7) tx_state_d = S_STOP;
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            default: begin
                if (tx_baud_q == BIT_LAST) begin
                    tx_baud_d  = '0;
                    tx_state_d = S_IDLE;
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    assign uart_tx_out = (tx_state_q == S_START) ? 1'b0 :
                         (tx_state_q == S_DATA)  ? tx_shift_q[0] : 1'b1;

    // ---------------- RX side ----------------
    logic               rx_meta_q, rx_sync_q;
    logic [7:0]         rx_mem_q [DEPTH];
    logic [FIFO_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [FIFO_AW:0]   rx_cnt_q, rx_cnt_d;
    uart_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0]   rx_baud_q, rx_baud_d;
    logic [2:0]         rx_idx_q, rx_idx_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic               rx_ovf_q, rx_ovf_d, rx_err_q, rx_err_d;
    logic               rx_push, rx_pop, rx_accept;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        rx_err_d   = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    rx_baud_d  = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                // Resample mid start bit; a high line here was a glitch.
                if (rx_baud_q == HALF_LAST) begin
                    rx_baud_d  = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_baud_q == BIT_LAST) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_idx_d   = rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            default: begin
                if (rx_baud_q == BIT_LAST) begin
                    rx_baud_d  = '0;
                    rx_state_d = S_IDLE;
                    rx_push    = rx_sync_q;
                    rx_err_d   = !rx_sync_q;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
        endcase
    end

    assign rx_pop    = cpu.cpu_rden_in && (rx_cnt_q != '0);
    // A full FIFO still takes the byte when the CPU frees a slot this cycle.
    assign rx_accept = rx_push && ((rx_cnt_q != FULL_CNT) || rx_pop);

    always_comb begin
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;
        rx_ovf_d    = rx_ovf_q | (rx_push && !rx_accept);
        if (rx_accept) rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
        if (rx_pop)    rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
        case ({rx_accept, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    assign cpu.serial_valid_out = (rx_cnt_q != '0);
    assign cpu.serial_data_out  = (rx_cnt_q != '0) ? rx_mem_q[rx_rd_ptr_q] : 8'h00;
    assign rx_overflow_out      = rx_ovf_q;
    assign rx_frame_err_out     = rx_err_q;

    // ---------------- registers ----------------
    always_ff @(posedge clock) begin
        if (tx_push)   tx_mem_q[tx_wr_ptr_q] <= cpu.cpu_data_in;
        if (rx_accept) rx_mem_q[rx_wr_ptr_q] <= rx_shift_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            tx_state_q  <= S_IDLE;
            tx_baud_q   <= '0;
            tx_idx_q    <= '0;
            tx_shift_q  <= '0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            rx_state_q  <= S_IDLE;
            rx_baud_q   <= '0;
            rx_idx_q    <= '0;
            rx_shift_q  <= '0;
            rx_ovf_q    <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_state_q  <= tx_state_d;
            tx_baud_q   <= tx_baud_d;
            tx_idx_q    <= tx_idx_d;
            tx_shift_q  <= tx_shift_d;
            rx_meta_q   <= uart_rx_in;
            rx_sync_q   <= rx_meta_q;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_state_q  <= rx_state_d;
            rx_baud_q   <= rx_baud_d;
            rx_idx_q    <= rx_idx_d;
            rx_shift_q  <= rx_shift_d;
            rx_ovf_q    <= rx_ovf_d;
            rx_err_q    <= rx_err_d;
        end
    end
endmodule

// File: tb/tb_serial_uart_endpoint.sv
module tb_serial_uart_endpoint;
    localparam int CPB = 4;
    localparam int AW  = 3;

    logic clock = 1'b0;
    logic reset;
    logic uart_rx;
    logic uart_tx;
    logic ovf;
    logic ferr;

    always #5 clock = ~clock;

    serial_uart_endpoint_if bus();

    serial_uart_endpoint #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clock            (clock),
        .reset            (reset),
        .cpu              (bus.slave),
        .uart_rx_in       (uart_rx),
        .uart_tx_out      (uart_tx),
        .rx_overflow_out  (ovf),
        .rx_frame_err_out (ferr)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    bit tx_mon_en = 1'b0;
    bit auto_read = 1'b0;
    int err_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // TX monitor: decodes frames on uart_tx and scores them against tx_exp_q.
    initial begin
        forever begin
            @(negedge clock);
            if (tx_mon_en && !reset && uart_tx === 1'b0) begin
                logic [7:0] b;
                repeat (CPB / 2) @(negedge clock);
                check("tx_start_bit", {31'b0, uart_tx}, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clock);
                check("tx_stop_bit", {31'b0, uart_tx}, 1);
                if (tx_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected_byte got=%02h expected=none", b);
                end else begin
                    check("tx_byte", {24'b0, b}, {24'b0, tx_exp_q.pop_front()});
                end
            end
        end
    end

    // RX monitor: when enabled, pops every presented byte and scores it.
    initial begin
        bus.cpu_rden_in = 1'b0;
        forever begin
            @(negedge clock);
            if (auto_read && !reset && bus.serial_valid_out) begin
                if (rx_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected_byte got=%02h expected=none", bus.serial_data_out);
                end else begin
                    check("rx_byte", {24'b0, bus.serial_data_out}, {24'b0, rx_exp_q.pop_front()});
                end
                bus.cpu_rden_in = 1'b1;
            end else begin
                bus.cpu_rden_in = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (ferr === 1'b1) err_cycles++;
        end
    end

    initial begin
        repeat (20000) @(posedge clock);
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic write_byte(input logic [7:0] b);
        @(posedge clock); #1;
        bus.cpu_wren_in = 1'b1;
        bus.cpu_data_in = b;
        @(posedge clock); #1;
        bus.cpu_wren_in = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clock); #1;
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clock);
            #1;
        end
        uart_rx = stop;
        repeat (CPB) @(posedge clock);
        #1;
    endtask

    task automatic wait_tx_drain(input int bound);
        int n = 0;
        while (tx_exp_q.size() != 0 && n < bound) begin
            @(negedge clock);
            n++;
        end
        check("tx_drain", tx_exp_q.size(), 0);
    endtask

    task automatic wait_rx_drain(input int bound);
        int n = 0;
        while (rx_exp_q.size() != 0 && n < bound) begin
            @(negedge clock);
            n++;
        end
        check("rx_drain", rx_exp_q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tx_line"}, {31'b0, uart_tx}, 1);
        check({tag, "_valid"},   {31'b0, bus.serial_valid_out}, 0);
        check({tag, "_ready"},   {31'b0, bus.serial_ready_out}, 1);
        check({tag, "_data"},    {24'b0, bus.serial_data_out}, 0);
        check({tag, "_ovf"},     {31'b0, ovf}, 0);
        check({tag, "_ferr"},    {31'b0, ferr}, 0);
    endtask

    initial begin
        bit exp_slots [10];
        int n;
        int e0;
        bit rdy_ok;
        bit stable_ok;
        bit idle_ok;
        logic mid;

        exp_slots = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        reset = 1'b1;
        uart_rx = 1'b1;
        bus.cpu_wren_in = 1'b0;
        bus.cpu_data_in = 8'h00;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_reset_state("reset");

        // Single TX byte 8'hA5, slot-by-slot line check.
        tx_mon_en = 1'b1;
        tx_exp_q.push_back(8'hA5);
        write_byte(8'hA5);
        n = 0;
        while (uart_tx !== 1'b0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("tx_a5_start_seen", {31'b0, uart_tx}, 0);
        rdy_ok = 1'b1;
        stable_ok = 1'b1;
        for (int s = 0; s < 10; s++) begin
            mid = 1'bx;
            for (int k = 0; k < CPB; k++) begin
                if (!(s == 0 && k == 0)) @(negedge clock);
                if (k == CPB / 2) mid = uart_tx;
                if (uart_tx !== exp_slots[s]) stable_ok = 1'b0;
                if (bus.serial_ready_out !== 1'b1) rdy_ok = 1'b0;
            end
            check($sformatf("tx_a5_slot%0d", s), {31'b0, mid}, {31'b0, exp_slots[s]});
        end
        check("tx_a5_slots_stable", {31'b0, stable_ok}, 1);
        check("tx_a5_ready_high", {31'b0, rdy_ok}, 1);
        @(negedge clock);
        check("tx_idle_after_frame", {31'b0, uart_tx}, 1);
        wait_tx_drain(100);
        repeat (5) @(negedge clock);

        // Fill the TX FIFO: 9 accepted, 10th (8'hFF) dropped.
        @(posedge clock); #1;
        bus.cpu_wren_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bus.cpu_data_in = (i == 10) ? 8'hFF : 8'(i);
            if (i <= 9) tx_exp_q.push_back(8'(i));
            @(negedge clock);
            if (i == 9)  check("tx_ready_before_9th", {31'b0, bus.serial_ready_out}, 1);
            if (i == 10) check("tx_ready_full_after_9th", {31'b0, bus.serial_ready_out}, 0);
            @(posedge clock); #1;
        end
        bus.cpu_wren_in = 1'b0;
        @(negedge clock);
        check("tx_ready_still_full", {31'b0, bus.serial_ready_out}, 0);
        wait_tx_drain(1000);
        repeat (5) @(negedge clock);
        check("tx_ready_after_drain", {31'b0, bus.serial_ready_out}, 1);

        // Single RX frame 8'h3C.
        auto_read = 1'b0;
        send_frame(8'h3C, 1'b1);
        n = 0;
        while (bus.serial_valid_out !== 1'b1 && n < 4) begin
            @(negedge clock);
            n++;
        end
        check("rx_valid_rise", {31'b0, bus.serial_valid_out}, 1);
        check("rx_data_3c", {24'b0, bus.serial_data_out}, 32'h3C);
        rx_exp_q.push_back(8'h3C);
        auto_read = 1'b1;
        wait_rx_drain(10);
        @(negedge clock);
        check("rx_valid_after_pop", {31'b0, bus.serial_valid_out}, 0);
        check("rx_data_after_pop", {24'b0, bus.serial_data_out}, 0);

        // Nine frames without reading: 8 kept, 9th overflows.
        auto_read = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send_frame(8'hB0 + 8'(i), 1'b1);
            if (i < 8) rx_exp_q.push_back(8'hB0 + 8'(i));
            if (i == 7) begin
                repeat (3) @(negedge clock);
                check("rx_valid_full", {31'b0, bus.serial_valid_out}, 1);
                check("rx_ovf_before_9th", {31'b0, ovf}, 0);
            end
        end
        repeat (3) @(negedge clock);
        check("rx_ovf_after_9th", {31'b0, ovf}, 1);
        auto_read = 1'b1;
        wait_rx_drain(40);
        @(negedge clock);
        check("rx_valid_after_drain", {31'b0, bus.serial_valid_out}, 0);

        // Frame with stop bit low.
        e0 = err_cycles;
        send_frame(8'h55, 1'b0);
        uart_rx = 1'b1;
        repeat (12) @(negedge clock);
        check("rx_ferr_pulse_cycles", err_cycles - e0, 1);
        check("rx_ferr_no_push", {31'b0, bus.serial_valid_out}, 0);
        check("rx_ovf_sticky", {31'b0, ovf}, 1);

        // One-cycle low glitch, then a clean frame.
        e0 = err_cycles;
        @(posedge clock); #1 uart_rx = 1'b0;
        @(posedge clock); #1 uart_rx = 1'b1;
        repeat (20) @(negedge clock);
        check("rx_glitch_no_err", err_cycles - e0, 0);
        check("rx_glitch_no_push", {31'b0, bus.serial_valid_out}, 0);
        rx_exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_rx_drain(10);

        // Reset in the middle of a TX frame and an RX frame.
        tx_mon_en = 1'b0;
        write_byte(8'h77);
        repeat (15) @(posedge clock);
        #1 uart_rx = 1'b0;
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_reset_state("midreset");
        @(posedge clock); #1;
        reset = 1'b0;
        uart_rx = 1'b1;
        idle_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) idle_ok = 1'b0;
        end
        check("tx_idle_after_reset", {31'b0, idle_ok}, 1);
        tx_mon_en = 1'b1;
        tx_exp_q.push_back(8'h96);
        write_byte(8'h96);
        rx_exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        wait_rx_drain(10);
        wait_tx_drain(100);
        repeat (5) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_uart_endpoint.md
Name: serial_uart_endpoint

Overview:
Device-side responder for the processor's byte-serial port: the far end of the data memory's serial_in/valid/ready/out/rden/wren handshake. CPU-written bytes enter a TX FIFO and are shifted out as 8N1 UART frames. Incoming 8N1 UART frames are deserialised into an RX FIFO, which the CPU pops via rden. Instantiated at top level beside the datapath; its ports connect one-to-one to the datapath's serial ports.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4
FIFO_AW, 3, log2 of the depth of each FIFO (depth 8)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
cpu_data_in  input  8  byte from the CPU (datapath serial_out)
cpu_wren_in  input  1  CPU write strobe (datapath serial_wren_out)
cpu_rden_in  input  1  CPU read/pop strobe (datapath serial_rden_out)
serial_data_out  output  8  RX FIFO head byte (to datapath serial_in)
serial_valid_out  output  1  RX FIFO non-empty (to datapath serial_valid_in)
serial_ready_out  output  1  TX FIFO not full (to datapath serial_ready_in)
uart_rx_in  input  1  asynchronous UART receive line, idle high
uart_tx_out  output  1  UART transmit line, idle high
rx_overflow_out  output  1  sticky: a received byte was dropped because the RX FIFO was full
rx_frame_err_out  output  1  one-cycle pulse: stop bit sampled low, byte discarded

Behaviour:
Reset:
- Both FIFOs empty. uart_tx_out=1, serial_valid_out=0, serial_ready_out=1, serial_data_out=8'h00, rx_overflow_out=0, rx_frame_err_out=0. Both FSMs go to IDLE.
- Reset mid-frame abandons the frame; the TX line is high in the cycle after the reset edge.

CPU side:
- serial_valid_out = (RX count != 0). serial_ready_out = (TX count != 2^FIFO_AW). Both come from registered counts.
- serial_data_out = RX head when valid, otherwise 8'h00. It is combinational from the FIFO storage.
- cpu_wren_in with ready=1: byte pushed at the edge. With ready=0: byte silently dropped, no state change.
- cpu_rden_in with valid=1: head popped at the edge. With valid=0: ignored.
- Write and read are independent and may occur in the same cycle.

TX FIFO simultaneous events:
- CPU push and TX pop in the same cycle: both occur and the count is unchanged.
- Push acceptance depends only on pre-edge ready. A pop in the same cycle does not rescue a write to a full FIFO.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: line=1. If TX FIFO is non-empty, pop the head into the shift register and go to START.
- START: line=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts them.
- STOP: line=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame = 10*CLKS_PER_BIT cycles. Back-to-back frames have no extra idle cycle beyond the one IDLE cycle.

RX path:
- uart_rx_in passes through a 2-flop synchroniser; FSM logic below uses the synchronised signal.
- IDLE: wait for the synchronised line = 0.
- START: wait CLKS_PER_BIT/2 (integer divide) cycles and resample. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
- DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first.
- STOP: after CLKS_PER_BIT cycles, sample.
  - Sample = 1: push the byte, then IDLE.
  - Sample = 0: pulse rx_frame_err_out for one cycle, discard the byte, return to IDLE. Do not push.
- Push when the RX FIFO is full:
  - With cpu_rden_in valid-pop in the same cycle: push succeeds and the count is unchanged.
  - Otherwise: byte dropped and rx_overflow_out set. It remains set until reset.

Counters:
- Baud counters are wide enough for CLKS_PER_BIT-1 and reload to 0 at each bit boundary.
- FIFO pointers are FIFO_AW bits, wrap modulo depth. Counts are FIFO_AW+1 bits.

Test Plan (CLKS_PER_BIT=4, FIFO_AW=3):
- Reset, then one write of 8'hA5:
  - uart_tx_out sequence per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1, then idle high.
  - serial_ready_out stays 1 throughout.
- Write 9 bytes 8'h01..8'h09 in consecutive cycles with the TX line stalled in a long frame:
  - First byte pops immediately; bytes 2..9 fill the FIFO.
  - serial_ready_out falls to 0 after the 9th accepted write.
  - A 10th write (8'hFF) is dropped; the transmitted order is 01..09 only.
- Drive an 8N1 frame 8'h3C on uart_rx_in:
  - serial_valid_out rises within 3 cycles after the stop-bit sample, with serial_data_out=8'h3C.
  - One cycle of cpu_rden_in returns valid to 0 and data to 8'h00.
- Drive 9 frames without reading:
  - After the 8th frame, valid=1 and the FIFO is full.
  - The 9th frame sets rx_overflow_out=1; the 8 stored bytes read back in order.
- Frame with stop bit 0: rx_frame_err_out pulses exactly 1 cycle, nothing is pushed, valid stays 0.
- Low glitch of 1 cycle on uart_rx_in: no push, no error, FSM returns to IDLE.
- Assert reset mid-TX-frame and mid-RX-frame:
  - Next cycle uart_tx_out=1, valid=0, ready=1, flags=0.
  - A following clean frame is received correctly.
